// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
// Holds the 3-bit operation encodings used on the mode port.
`timescale 1ns/1ps
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROTL = 3'd4;
  localparam logic [2:0] MODE_ROTR = 3'd5;
  localparam logic [2:0] MODE_ASHR = 3'd6;
  localparam logic [2:0] MODE_RSVD = 3'd7;

endpackage

// File: rtl/usr_next_val.sv
// Combinational next-state datapath for universal_shift_reg.
// Ports:
//   mode     operation select
//   q        current register word
//   d        parallel load data
//   sin      serial input bit
//   q_nxt    word to register if the operation is performed
//   sout_nxt bit leaving the word (only meaningful when is_shift=1)
//   is_shift 1 for SHL/SHR/ROTL/ROTR/ASHR
`timescale 1ns/1ps
module usr_next_val
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q_nxt,
  output logic             sout_nxt,
  output logic             is_shift
);

  always_comb begin
    q_nxt    = q;
    sout_nxt = 1'b0;
    is_shift = 1'b0;
    case (mode)
      MODE_LOAD: q_nxt = d;
      MODE_SHL: begin
        q_nxt    = {q[WIDTH-2:0], sin};
        sout_nxt = q[WIDTH-1];
        is_shift = 1'b1;
      end
      MODE_SHR: begin
        q_nxt    = {sin, q[WIDTH-1:1]};
        sout_nxt = q[0];
        is_shift = 1'b1;
      end
      MODE_ROTL: begin
        q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
        sout_nxt = q[WIDTH-1];
        is_shift = 1'b1;
      end
      MODE_ROTR: begin
        q_nxt    = {q[0], q[WIDTH-1:1]};
        sout_nxt = q[0];
        is_shift = 1'b1;
      end
      MODE_ASHR: begin
        q_nxt    = {q[WIDTH-1], q[WIDTH-1:1]};
        sout_nxt = q[0];
        is_shift = 1'b1;
      end
      default: q_nxt = q;  // HOLD and the reserved encoding
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal register: hold, parallel load, logical shift,
// rotate and arithmetic shift right, with serial in/out and a modulo-WIDTH
// shift counter that pulses wrap after each completed full-word shift.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   en     operation enable
//   clr    synchronous clear (beats en and mode)
//   mode   operation select (usr_pkg encodings)
//   D      parallel load data
//   sin    serial input bit
//   Q      registered word
//   sout   bit shifted/rotated out by the last shift op
//   cnt    shift ops since last load/clear, modulo WIDTH
//   wrap   1-cycle pulse when cnt goes WIDTH-1 -> 0
`timescale 1ns/1ps
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin,
  output logic [WIDTH-1:0] Q,
  output logic             sout,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q_nxt;
  logic             sout_nxt;
  logic             is_shift;

  usr_next_val #(.WIDTH(WIDTH)) u_next_val (
    .mode     (mode),
    .q        (Q),
    .d        (D),
    .sin      (sin),
    .q_nxt    (q_nxt),
    .sout_nxt (sout_nxt),
    .is_shift (is_shift)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q    <= RESET_VAL;
      sout <= 1'b0;
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      Q    <= RESET_VAL;
      sout <= 1'b0;
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (!en) begin
      wrap <= 1'b0;
    end else begin
      Q    <= q_nxt;
      wrap <= 1'b0;
      if (mode == MODE_LOAD) begin
        cnt <= '0;
      end else if (is_shift) begin
        sout <= sout_nxt;
        // explicit compare keeps cnt within 0..WIDTH-1 for non-power-of-two widths
        if (cnt == CNT_MAX) begin
          cnt  <= '0;
          wrap <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
`timescale 1ns/1ps
module tb_universal_shift_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [2:0] mode = 3'd0;
  logic       sin = 1'b0;
  logic [7:0] d8 = '0;
  logic [4:0] d5 = '0;

  logic [7:0] q8;
  logic       sout8;
  logic [2:0] cnt8;
  logic       wrap8;
  logic [4:0] q5;
  logic       sout5;
  logic [2:0] cnt5;
  logic       wrap5;

  int total = 0;
  int bad = 0;

  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .D(d8), .sin(sin),
    .Q(q8), .sout(sout8), .cnt(cnt8), .wrap(wrap8));

  universal_shift_reg #(.WIDTH(5), .RESET_VAL(5'h15)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .D(d5), .sin(sin),
    .Q(q5), .sout(sout5), .cnt(cnt5), .wrap(wrap5));

  initial begin
    #10;
    forever #5 clk = ~clk;
  end

  // Reference model, index 0 = 8-bit instance, 1 = 5-bit instance.
  int          mwid[2] = '{8, 5};
  logic [31:0] mrv[2]  = '{32'h00, 32'h15};
  logic [31:0] mq[2];
  logic        ms[2];
  int          mc[2];
  logic        mw[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = mrv[i]; ms[i] = 1'b0; mc[i] = 0; mw[i] = 1'b0;
    end
  endtask

  task automatic model_tick(input int i, input logic [31:0] d);
    int w;
    logic [31:0] mask, q, msb, lsb;
    w    = mwid[i];
    mask = (32'h1 << w) - 1;
    q    = mq[i];
    msb  = (q >> (w - 1)) & 32'h1;
    lsb  = q & 32'h1;
    mw[i] = 1'b0;
    if (clr) begin
      mq[i] = mrv[i]; ms[i] = 1'b0; mc[i] = 0;
    end else if (en) begin
      case (int'(mode))
        1: begin mq[i] = d & mask; mc[i] = 0; end
        2: begin ms[i] = msb[0]; mq[i] = ((q << 1) | 32'(sin)) & mask; end
        3: begin ms[i] = lsb[0]; mq[i] = (q >> 1) | (32'(sin) << (w - 1)); end
        4: begin ms[i] = msb[0]; mq[i] = ((q << 1) | msb) & mask; end
        5: begin ms[i] = lsb[0]; mq[i] = (q >> 1) | (lsb << (w - 1)); end
        6: begin ms[i] = lsb[0]; mq[i] = (q >> 1) | (msb << (w - 1)); end
        default: ;
      endcase
      if (mode >= 3'd2 && mode <= 3'd6) begin
        mc[i] = (mc[i] + 1) % w;
        mw[i] = (mc[i] == 0);
      end
    end
  endtask

  // One clock edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_tick(0, 32'(d8));
      model_tick(1, 32'(d5));
    end
    #1;
  endtask

  task automatic op(input logic [2:0] m, input logic [7:0] d, input logic s);
    en = 1'b1; clr = 1'b0; mode = m; d8 = d; d5 = d[4:0]; sin = s;
    step();
  endtask

  task automatic test_reset();
    #0.5 rst_n = 1'b0;
    #0.5;
    model_reset();
    total++;
    if (q8 !== 8'h00 || sout8 !== 1'b0 || cnt8 !== 3'd0 || wrap8 !== 1'b0) begin
      bad++;
      $display("FAIL reset_async8: Q=%h sout=%b cnt=%0d wrap=%b want 00 0 0 0", q8, sout8, cnt8, wrap8);
    end
    total++;
    if (q5 !== 5'h15 || cnt5 !== 3'd0) begin
      bad++;
      $display("FAIL reset_async5: Q=%h cnt=%0d want 15 0", q5, cnt5);
    end
    for (int k = 0; k < 6; k++) begin
      en = 1'($urandom); mode = 3'($urandom); d8 = 8'($urandom); d5 = 5'($urandom);
      sin = 1'($urandom);
      step();
      total++;
      if (q8 !== 8'h00 || sout8 !== 1'b0 || cnt8 !== 3'd0 || wrap8 !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: Q=%h sout=%b cnt=%0d wrap=%b want all 0", q8, sout8, cnt8, wrap8);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load_shl();
    logic [7:0] exp_q[8] = '{8'h4B, 8'h97, 8'h2F, 8'h5F, 8'hBF, 8'h7F, 8'hFF, 8'hFF};
    logic       exp_s[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    op(3'd1, 8'hA5, 1'b0);
    total++;
    if (q8 !== 8'hA5 || cnt8 !== 3'd0) begin
      bad++;
      $display("FAIL load: Q=%h cnt=%0d want a5 0", q8, cnt8);
    end
    for (int k = 0; k < 8; k++) begin
      op(3'd2, 8'h00, 1'b1);
      total++;
      if (q8 !== exp_q[k] || sout8 !== exp_s[k] || wrap8 !== (k == 7) ||
          cnt8 !== 3'((k + 1) % 8)) begin
        bad++;
        $display("FAIL shl_%0d: Q=%h sout=%b wrap=%b cnt=%0d want %h %b %b %0d", k, q8, sout8,
                 wrap8, cnt8, exp_q[k], exp_s[k], (k == 7), (k + 1) % 8);
      end
    end
  endtask

  task automatic test_rotate();
    int wraps;
    op(3'd1, 8'h81, 1'b0);
    op(3'd5, 8'h00, 1'b0);
    total++;
    if (q8 !== 8'hC0 || sout8 !== 1'b1) begin
      bad++;
      $display("FAIL rotr: Q=%h sout=%b want c0 1", q8, sout8);
    end
    op(3'd1, 8'h80, 1'b0);
    op(3'd6, 8'h00, 1'b1);
    total++;
    if (q8 !== 8'hC0 || sout8 !== 1'b0) begin
      bad++;
      $display("FAIL ashr: Q=%h sout=%b want c0 0", q8, sout8);
    end
    op(3'd1, 8'h3C, 1'b0);
    wraps = 0;
    for (int k = 0; k < 8; k++) begin
      op(3'd4, 8'h00, 1'($urandom));
      if (wrap8 === 1'b1) wraps++;
    end
    total++;
    if (q8 !== 8'h3C || wraps != 1) begin
      bad++;
      $display("FAIL rotl8: Q=%h wraps=%0d want 3c 1", q8, wraps);
    end
  endtask

  task automatic test_priority();
    op(3'd1, 8'h3C, 1'b0);
    op(3'd2, 8'h00, 1'b0);
    op(3'd2, 8'h00, 1'b0);
    op(3'd2, 8'h00, 1'b0);
    total++;
    if (q8 !== 8'hE0 || cnt8 !== 3'd3) begin
      bad++;
      $display("FAIL pre_clr: Q=%h cnt=%0d want e0 3", q8, cnt8);
    end
    clr = 1'b1; en = 1'b1; mode = 3'd1; d8 = 8'hFF; d5 = 5'h1F;
    step();
    clr = 1'b0;
    total++;
    if (q8 !== 8'h00 || sout8 !== 1'b0 || cnt8 !== 3'd0 || q5 !== 5'h15) begin
      bad++;
      $display("FAIL clr: Q=%h sout=%b cnt=%0d Q5=%h want 00 0 0 15", q8, sout8, cnt8, q5);
    end
    op(3'd1, 8'h3C, 1'b0);
    op(3'd2, 8'h00, 1'b0);
    op(3'd2, 8'h00, 1'b0);
    en = 1'b0; mode = 3'd2; sin = 1'b1;
    step();
    total++;
    if (q8 !== 8'hF0 || cnt8 !== 3'd2 || wrap8 !== 1'b0) begin
      bad++;
      $display("FAIL en_low: Q=%h cnt=%0d wrap=%b want f0 2 0", q8, cnt8, wrap8);
    end
    op(3'd7, 8'hAA, 1'b1);
    total++;
    if (q8 !== 8'hF0 || cnt8 !== 3'd2 || wrap8 !== 1'b0) begin
      bad++;
      $display("FAIL rsvd_hold: Q=%h cnt=%0d wrap=%b want f0 2 0", q8, cnt8, wrap8);
    end
  endtask

  task automatic test_reset_mid();
    op(3'd1, 8'hD7, 1'b0);
    for (int k = 0; k < 5; k++) op(3'd3, 8'h00, 1'($urandom));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (q8 !== 8'h00 || cnt8 !== 3'd0 || sout8 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: Q=%h cnt=%0d sout=%b want 00 0 0", q8, cnt8, sout8);
    end
    #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      op(3'd2, 8'h00, 1'($urandom));
      total++;
      if (wrap8 !== (k == 7)) begin
        bad++;
        $display("FAIL post_reset_wrap_%0d: wrap=%b want %b", k, wrap8, (k == 7));
      end
    end
  endtask

  task automatic test_random();
    int wraps5;
    wraps5 = 0;
    for (int k = 0; k < 1000; k++) begin
      clr  = ($urandom_range(0, 19) == 0);
      en   = ($urandom_range(0, 3) != 0);
      mode = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'($urandom);
      d8   = 8'($urandom);
      d5   = 5'($urandom);
      sin  = 1'($urandom);
      step();
      total++;
      if (32'(q8) !== mq[0] || sout8 !== ms[0] || 32'(cnt8) !== 32'(mc[0]) || wrap8 !== mw[0]) begin
        bad++;
        $display("FAIL rand8_%0d: Q=%h sout=%b cnt=%0d wrap=%b want %h %b %0d %b", k, q8, sout8,
                 cnt8, wrap8, mq[0][7:0], ms[0], mc[0], mw[0]);
      end
      total++;
      if (32'(q5) !== mq[1] || sout5 !== ms[1] || 32'(cnt5) !== 32'(mc[1]) || wrap5 !== mw[1]) begin
        bad++;
        $display("FAIL rand5_%0d: Q=%h sout=%b cnt=%0d wrap=%b want %h %b %0d %b", k, q5, sout5,
                 cnt5, wrap5, mq[1][4:0], ms[1], mc[1], mw[1]);
      end
      if (wrap5 === 1'b1) wraps5++;
    end
    total++;
    if (wraps5 == 0) begin
      bad++;
      $display("FAIL rand5_wrap_seen: wraps=%0d want >0", wraps5);
    end
  endtask

  initial begin
    test_reset();
    test_load_shl();
    test_rotate();
    test_priority();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
